// File: rtl/run_dump_ctrl_if.sv
// Dump stream bundle: valid/ready word transport from run_dump_ctrl to its consumer.
// Handshake: a word transfers on a rising edge where dump_valid && dump_ready; while
// dump_valid is high and dump_ready is low, dump_data and dump_last are held unchanged.
interface run_dump_ctrl_if #(
    parameter int XLEN = 64
);
    logic            dump_valid;
    logic            dump_ready;
    logic [XLEN-1:0] dump_data;
    logic            dump_last;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/run_dump_ctrl.sv
// End-of-run controller: counts cycles, detects program completion from the PC or an
// all-ones instruction, halts the CPU, then streams x0..x31 and the cycle count.
module run_dump_ctrl #(
    parameter int XLEN         = 64,
    parameter int END_PC       = 60,
    parameter int STABLE_LIMIT = 8,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [31:0]      instr_in,
    output logic [4:0]       rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic             cpu_halt,
    run_dump_ctrl_if.master  dump,
    output logic [CNT_W-1:0] cycle_count,
    output logic             halt_cause,
    output logic             done,
    output logic [1:0]       dbg_state
);
    localparam int              SW       = $clog2(STABLE_LIMIT + 1);
    localparam logic [XLEN-1:0] END_PC_V = XLEN'(END_PC);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cycle;
    logic [SW-1:0]     r_stable;
    logic [XLEN-1:0]   r_prev_pc;
    logic [5:0]        r_idx;
    logic              r_halt_cause;
    logic              r_done;
    logic              r_dump_valid;
    logic              r_dump_last;
    logic [XLEN-1:0]   r_dump_data;

    logic [CNT_W-1:0]  w_cycle_nxt;
    logic [SW-1:0]     w_stable_nxt;
    logic              w_pc_hit;
    logic              w_stable_hit;
    logic              w_illegal;
    logic              w_complete;
    logic              w_accept_last;
    logic              w_load;
    logic [XLEN-1:0]   w_count_word;

    always_comb begin
        w_cycle_nxt   = (&r_cycle) ? r_cycle : r_cycle + 1'b1;
        w_stable_nxt  = '0;
        if (pc_in == r_prev_pc)
            w_stable_nxt = (&r_stable) ? r_stable : r_stable + 1'b1;
        w_pc_hit      = (pc_in >= END_PC_V);
        w_stable_hit  = (w_stable_nxt == SW'(STABLE_LIMIT));
        w_illegal     = (instr_in == 32'hFFFF_FFFF);
        w_complete    = w_pc_hit || w_stable_hit || w_illegal;
        w_accept_last = r_dump_valid && dump.dump_ready && r_dump_last;
        // Index 33 means the count word is already loaded; nothing further to fetch.
        w_load        = (!r_dump_valid || dump.dump_ready) && (r_idx <= 6'd32);
        w_count_word  = {{(XLEN-CNT_W){1'b0}}, r_cycle};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_cycle      <= '0;
            r_stable     <= '0;
            r_prev_pc    <= '0;
            r_idx        <= '0;
            r_halt_cause <= 1'b0;
            r_done       <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_last  <= 1'b0;
            r_dump_data  <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_cycle   <= w_cycle_nxt;
                    r_stable  <= w_stable_nxt;
                    r_prev_pc <= pc_in;
                    if (w_complete) begin
                        r_state      <= ST_DUMP;
                        // PC reaching END_PC outranks the stable/illegal causes.
                        r_halt_cause <= !w_pc_hit;
                    end
                end
                ST_DUMP: begin
                    if (w_accept_last) begin
                        r_dump_valid <= 1'b0;
                        r_dump_last  <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= ST_DONE;
                    end else if (w_load) begin
                        r_dump_valid <= 1'b1;
                        r_idx        <= r_idx + 1'b1;
                        if (r_idx[5]) begin
                            r_dump_data <= w_count_word;
                            r_dump_last <= 1'b1;
                        end else begin
                            r_dump_data <= rf_rdata;
                        end
                    end
                end
                ST_DONE: ;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign rf_raddr        = r_idx[5] ? 5'd0 : r_idx[4:0];
    assign cpu_halt        = (r_state != ST_RUN);
    assign cycle_count     = r_cycle;
    assign halt_cause      = r_halt_cause;
    assign done            = r_done;
    assign dbg_state       = r_state;
    assign dump.dump_valid = r_dump_valid;
    assign dump.dump_data  = r_dump_data;
    assign dump.dump_last  = r_dump_last;
endmodule

// File: tb/tb_run_dump_ctrl.sv
// Directed bench for run_dump_ctrl: completion causes, full dump, backpressure, reset mid-dump.
module tb_run_dump_ctrl;
    logic        clk;
    logic        reset;
    logic [63:0] pc_in;
    logic [31:0] instr_in;
    logic [4:0]  rf_raddr;
    logic [63:0] rf_rdata;
    logic        cpu_halt;
    logic [31:0] cycle_count;
    logic        halt_cause;
    logic        done;
    logic [1:0]  dbg_state;

    logic [63:0] rf [32];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    bit          got_last_q[$];
    int          checks;
    int          errors;
    int          first_valid_edge;
    int          done_edge;
    int          hold_viol;
    int          stall_cycles;

    run_dump_ctrl_if #(.XLEN(64)) u_if ();

    run_dump_ctrl #(
        .XLEN(64), .END_PC(60), .STABLE_LIMIT(8), .CNT_W(32)
    ) u_dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .cpu_halt(cpu_halt),
        .dump(u_if.master), .cycle_count(cycle_count), .halt_cause(halt_cause),
        .done(done), .dbg_state(dbg_state)
    );

    assign rf_rdata = rf[rf_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        pc_in = '0;
        instr_in = '0;
        u_if.dump_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // PC walks 0,4,...,60; the 16th edge is the completion edge.
    task automatic run_ramp();
        for (int i = 0; i < 16; i++) begin
            pc_in = 64'(4 * i);
            @(posedge clk); #1;
        end
    endtask

    // Drives dump_ready (mode 0: always 1, mode 1: 1,0,0 repeating) and records accepted words.
    task automatic collect_dump(input int mode);
        logic [63:0] held_data;
        logic        held_last;
        bit          holding;
        got_q.delete();
        got_last_q.delete();
        first_valid_edge = -1;
        done_edge = -1;
        hold_viol = 0;
        stall_cycles = 0;
        for (int t = 0; t < 400; t++) begin
            u_if.dump_ready = (mode == 0) ? 1'b1 : ((t % 3) == 0);
            holding = 1'b0;
            if (u_if.dump_valid && u_if.dump_ready) begin
                got_q.push_back(u_if.dump_data);
                got_last_q.push_back(u_if.dump_last);
            end else if (u_if.dump_valid) begin
                holding = 1'b1;
                held_data = u_if.dump_data;
                held_last = u_if.dump_last;
                stall_cycles++;
            end
            @(posedge clk); #1;
            if (holding && (u_if.dump_valid !== 1'b1 || u_if.dump_data !== held_data ||
                            u_if.dump_last !== held_last))
                hold_viol++;
            if (first_valid_edge < 0 && u_if.dump_valid === 1'b1) first_valid_edge = t + 1;
            if (done === 1'b1) begin
                done_edge = t + 1;
                break;
            end
        end
        u_if.dump_ready = 1'b0;
    endtask

    task automatic build_exp(input logic [63:0] count);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(rf[i]);
        exp_q.push_back(count);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pc_in = 64'h1234;
        instr_in = '0;
        u_if.dump_ready = 1'b0;
        #1;
        checks++;
        if ({cpu_halt, u_if.dump_valid, u_if.dump_last, halt_cause, done} !== 5'b0 ||
            u_if.dump_data !== 64'd0 || cycle_count !== 32'd0 || rf_raddr !== 5'd0 ||
            dbg_state !== 2'd0) begin
            $display("FAIL reset_outputs: halt=%b valid=%b last=%b cause=%b done=%b data=%h cnt=%0d raddr=%0d st=%0d, required all 0",
                     cpu_halt, u_if.dump_valid, u_if.dump_last, halt_cause, done,
                     u_if.dump_data, cycle_count, rf_raddr, dbg_state);
            errors++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_pc_completion();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            pc_in = 64'(4 * i);
            @(posedge clk); #1;
        end
        checks++;
        if (cpu_halt !== 1'b0 || cycle_count !== 32'd15) begin
            $display("FAIL pc_pre_completion: halt=%b cnt=%0d, required halt=0 cnt=15", cpu_halt, cycle_count);
            errors++;
        end
        pc_in = 64'd60;
        @(posedge clk); #1;
        checks++;
        if (cpu_halt !== 1'b1 || cycle_count !== 32'd16 || halt_cause !== 1'b0 ||
            u_if.dump_valid !== 1'b0) begin
            $display("FAIL pc_completion: halt=%b cnt=%0d cause=%b valid=%b, required 1/16/0/0",
                     cpu_halt, cycle_count, halt_cause, u_if.dump_valid);
            errors++;
        end
        build_exp(64'd16);
        collect_dump(0);
        checks++;
        if (first_valid_edge != 1 || done_edge != 34) begin
            $display("FAIL full_dump_timing: first_valid=%0d done=%0d, required 1 and 34",
                     first_valid_edge, done_edge);
            errors++;
        end
        checks++;
        if (got_q.size() != 33) begin
            $display("FAIL full_dump_count: got %0d words, required 33", got_q.size());
            errors++;
        end else begin
            for (int i = 0; i < 33; i++) begin
                if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 32)) begin
                    $display("FAIL full_dump_word%0d: data=%h last=%b, required data=%h last=%b",
                             i, got_q[i], got_last_q[i], exp_q[i], (i == 32));
                    errors++;
                end
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || u_if.dump_valid !== 1'b0 || cycle_count !== 32'd16 || cpu_halt !== 1'b1) begin
            $display("FAIL done_state: done=%b valid=%b cnt=%0d halt=%b, required 1/0/16/1",
                     done, u_if.dump_valid, cycle_count, cpu_halt);
            errors++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        run_ramp();
        build_exp(64'd16);
        collect_dump(1);
        checks++;
        if (hold_viol != 0) begin
            $display("FAIL bp_hold: %0d stall cycles changed the word, required 0", hold_viol);
            errors++;
        end
        checks++;
        if (done_edge != 34 + stall_cycles || stall_cycles == 0) begin
            $display("FAIL bp_latency: done edge=%0d stalls=%0d, required done=%0d with stalls>0",
                     done_edge, stall_cycles, 34 + stall_cycles);
            errors++;
        end
        checks++;
        if (got_q.size() != 33) begin
            $display("FAIL bp_count: got %0d words, required 33", got_q.size());
            errors++;
        end else begin
            for (int i = 0; i < 33; i++) begin
                if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 32)) begin
                    $display("FAIL bp_word%0d: data=%h last=%b, required data=%h last=%b",
                             i, got_q[i], got_last_q[i], exp_q[i], (i == 32));
                    errors++;
                end
            end
        end
    endtask

    // PC 4,8,12,16 then 20 held from edge 5; edges 6..13 are equal samples, 13 is the 8th.
    task automatic test_stable_pc();
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            pc_in = (e < 5) ? 64'(4 * e) : 64'd20;
            @(posedge clk); #1;
        end
        checks++;
        if (cpu_halt !== 1'b0 || cycle_count !== 32'd12) begin
            $display("FAIL stable_pre: halt=%b cnt=%0d, required halt=0 cnt=12", cpu_halt, cycle_count);
            errors++;
        end
        @(posedge clk); #1;
        checks++;
        if (cpu_halt !== 1'b1 || cycle_count !== 32'd13 || halt_cause !== 1'b1) begin
            $display("FAIL stable_halt: halt=%b cnt=%0d cause=%b, required 1/13/1",
                     cpu_halt, cycle_count, halt_cause);
            errors++;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pc_in = 64'd64;
        instr_in = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        instr_in = '0;
        checks++;
        if (cpu_halt !== 1'b1 || cycle_count !== 32'd1 || halt_cause !== 1'b0) begin
            $display("FAIL simultaneous: halt=%b cnt=%0d cause=%b, required 1/1/0",
                     cpu_halt, cycle_count, halt_cause);
            errors++;
        end
    endtask

    task automatic test_illegal();
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            pc_in = 64'(4 * (e - 1));
            @(posedge clk); #1;
        end
        checks++;
        if (cpu_halt !== 1'b0) begin
            $display("FAIL illegal_pre: halt=%b, required 0", cpu_halt);
            errors++;
        end
        pc_in = 64'd16;
        instr_in = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        instr_in = '0;
        checks++;
        if (cpu_halt !== 1'b1 || cycle_count !== 32'd5 || halt_cause !== 1'b1) begin
            $display("FAIL illegal_halt: halt=%b cnt=%0d cause=%b, required 1/5/1",
                     cpu_halt, cycle_count, halt_cause);
            errors++;
        end
    endtask

    task automatic test_reset_mid_dump();
        do_reset();
        run_ramp();
        u_if.dump_ready = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (u_if.dump_valid !== 1'b1 || u_if.dump_data !== rf[11]) begin
            $display("FAIL middump_position: valid=%b data=%h, required 1 and %h",
                     u_if.dump_valid, u_if.dump_data, rf[11]);
            errors++;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({cpu_halt, u_if.dump_valid, u_if.dump_last, halt_cause, done} !== 5'b0 ||
            u_if.dump_data !== 64'd0 || cycle_count !== 32'd0 || rf_raddr !== 5'd0 ||
            dbg_state !== 2'd0) begin
            $display("FAIL middump_reset: halt=%b valid=%b data=%h cnt=%0d raddr=%0d st=%0d, required all 0",
                     cpu_halt, u_if.dump_valid, u_if.dump_data, cycle_count, rf_raddr, dbg_state);
            errors++;
        end
        u_if.dump_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        pc_in = 64'd4;
        @(posedge clk); #1;
        checks++;
        if (cycle_count !== 32'd1 || cpu_halt !== 1'b0) begin
            $display("FAIL rerun_first_cycle: cnt=%0d halt=%b, required 1 and 0", cycle_count, cpu_halt);
            errors++;
        end
        for (int e = 2; e <= 16; e++) begin
            pc_in = 64'(4 * (e - 1));
            @(posedge clk); #1;
        end
        build_exp(64'd16);
        collect_dump(0);
        checks++;
        if (got_q.size() != 33 || done_edge != 34) begin
            $display("FAIL rerun_dump: words=%0d done_edge=%0d, required 33 and 34", got_q.size(), done_edge);
            errors++;
        end else begin
            for (int i = 0; i < 33; i++) begin
                if (got_q[i] !== exp_q[i]) begin
                    $display("FAIL rerun_word%0d: data=%h, required %h", i, got_q[i], exp_q[i]);
                    errors++;
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) rf[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        test_reset();
        test_pc_completion();
        test_backpressure();
        test_stable_pc();
        test_simultaneous();
        test_illegal();
        test_reset_mid_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
